weight_stream_sched: RTL and testbench
======================================

Name: weight_stream_sched

Overview:
- Sequences the per-timestep LSTM weight stream from the external memory reader into the gate weight-FIFO write port (wr_fifo_data / wr_fifo_data_valid).
- Issues fixed-length bursts and throttles them against the FIFO almost-full back-pressure (fifo_ready).
- Guarantees each frame is an exact multiple of 4 words, so the downstream 4-FIFO round-robin never loses alignment.
- Optionally loops the frame once per timestep. Lives entirely in the clk_200m domain.

Parameters:
- HIDDEN_SIZE, 512, LSTM hidden size.
- INPUT_SIZE, 96, LSTM input features.
- BURST_LEN, 64, 16-bit beats per burst. Multiple of 4; must divide TOTAL_WORDS.
- ADDR_W, 32, byte-address width.
- BASE_ADDR, 0, byte address of word 0.
- TOTAL_WORDS (localparam), HIDDEN_SIZE*HIDDEN_SIZE*5/2 + INPUT_SIZE*HIDDEN_SIZE*2 = 753664, 16-bit words per frame.

Ports:
- clk_200m  in  1  clock
- rst  in  1  async reset, active-high
- start  in  1  pulse; begin frame
- loop_en  in  1  restart a frame automatically after done
- stop  in  1  pulse; halt at next burst boundary
- rd_req  out  1  burst request; held until rd_ack
- rd_addr  out  ADDR_W  burst byte address
- rd_len  out  16  burst length = BURST_LEN
- rd_ack  in  1  request accepted (1-cycle)
- rd_data_valid  in  1  beat valid
- rd_data  in  16  beat data
- rd_data_ready  out  1  high only in XFER
- fifo_ready  in  1  inverse of any gate-FIFO almost-full
- wr_fifo_data_valid  out  1  write strobe to gate FIFOs
- wr_fifo_data  out  16  write data
- busy  out  1  state != IDLE
- done  out  1  1-cycle end-of-frame pulse
- frame_cnt  out  16  completed frames, wraps
- protocol_err  out  1  sticky: beat arrived outside XFER
- stall_cycles  out  32  optional-feature counter

Behaviour:
- Reset values: all outputs 0; state IDLE; word_idx=0; beat_cnt=0; stop_pend=0. Reset mid-burst drops rd_req immediately, no completion.
- States:
  - IDLE: start && !stop -> REQ, word_idx=0. Start is ignored when busy. If start and stop arrive together, stop wins.
  - REQ: rd_req=1 only while fifo_ready=1. Deasserting fifo_ready before ack withdraws the request. rd_ack -> XFER, beat_cnt=0.
  - XFER: rd_data_ready=1. Each rd_data_valid registers the beat (1-cycle latency to wr_fifo_data_valid/wr_fifo_data) and increments beat_cnt and word_idx. When beat_cnt reaches BURST_LEN: if word_idx==TOTAL_WORDS -> DONE; else if stop_pend -> IDLE; else REQ.
  - DONE: single cycle. done=1, frame_cnt++, word_idx=0. Then loop_en && !stop_pend -> REQ, else IDLE. stop_pend clears on entering IDLE.
- rd_addr = BASE_ADDR + 2*word_idx, registered on entry to REQ and stable while rd_req is high.
- The fifo_ready headroom (almost-full threshold) must absorb one full burst; no mid-burst throttle.
- stop in XFER or REQ sets stop_pend. stop in REQ with no ack yet -> IDLE next cycle. A partial frame is therefore always a whole number of bursts, i.e. a multiple of 4 words.
- rd_data_valid outside XFER: beat dropped, protocol_err=1 until reset.
- word_idx width is ceil(log2(TOTAL_WORDS+1)); compare is exact, with no wrap beyond TOTAL_WORDS.

Optional Feature:
- Macro: WSCHED_STALL_CNT_EN.
- Defined: stall_cycles counts cycles in REQ with fifo_ready=0. It saturates at 2^32-1 and clears on start accepted in IDLE.
- Undefined: stall_cycles tied to 0; no counter logic.

Decomposition:
- Shared package: state enum (IDLE, REQ, XFER, DONE); TOTAL_WORDS computation from HIDDEN_SIZE/INPUT_SIZE, shared with the weight-FIFO length constants.
- One natural sub-module: wsched_burst_ctr, a beat counter with terminal flag, parameterised by BURST_LEN.
- The FSM stays in the top module.

Test Plan:
- Reduced params (HIDDEN 8, INPUT 4, BURST 8 -> TOTAL 224): start, reader always acks and streams with fifo_ready=1 -> 28 bursts at rd_addr 0,16,...,432; 224 write strobes; done once; frame_cnt=1; returns to IDLE.
- fifo_ready=0 for 50 cycles before the 3rd burst -> rd_req low during the stall, no write strobes; stall_cycles=50 with WSCHED_STALL_CNT_EN, 0 without.
- loop_en=1 for 3 frames -> address restarts at BASE_ADDR after each done; frame_cnt=3; strobe count 672.
- stop pulsed mid-burst 5 -> burst 5 completes (40 strobes total), then IDLE. Fresh start resumes at rd_addr 0.
- rd_data_valid injected in IDLE -> no strobe; protocol_err=1 and held. Async rst mid-XFER -> all outputs 0 within the reset, protocol_err cleared.
- start asserted while busy, and start+stop in the same cycle in IDLE -> both ignored; no rd_req.

Source files
------------

// File: rtl/weight_stream_sched_pkg.sv
// Shared types and sizing for the LSTM weight stream scheduler and the gate weight FIFOs.
package weight_stream_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } wsched_state_t;

  // Downstream round-robin spreads words across this many gate FIFOs.
  localparam int unsigned GATE_FIFO_CNT = 4;

  // 16-bit words in one timestep's weight frame.
  function automatic int unsigned lstm_total_words(input int unsigned hidden_size,
                                                   input int unsigned input_size);
    return hidden_size * hidden_size * 5 / 2 + input_size * hidden_size * 2;
  endfunction

  // Words each gate FIFO receives per frame.
  function automatic int unsigned gate_fifo_words(input int unsigned hidden_size,
                                                  input int unsigned input_size);
    return lstm_total_words(hidden_size, input_size) / GATE_FIFO_CNT;
  endfunction

endpackage

// File: rtl/wsched_burst_ctr.sv
// Beat counter for one read burst; term flags the final beat position.
module wsched_burst_ctr #(
  parameter int unsigned BURST_LEN = 64
) (
  input  logic clk_200m,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  logic [CNT_W-1:0] beat_cnt;

  assign term = (beat_cnt == CNT_W'(BURST_LEN - 1));

  // Count accepted beats; cleared when a new burst is acknowledged.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst)      beat_cnt <= '0;
    else if (clr) beat_cnt <= '0;
    else if (inc) beat_cnt <= beat_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/weight_stream_sched.sv
// Weight stream scheduler: pulls fixed-length bursts from the memory reader and writes
// them into the gate weight FIFOs, one whole frame per timestep.
// Build option: define WSCHED_STALL_CNT_EN to count REQ cycles blocked by fifo_ready.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | burst request outstanding, gated by fifo_ready
// XFER  | accepting BURST_LEN beats from the reader
// DONE  | one-cycle end-of-frame, optional loop back to REQ
module weight_stream_sched
  import weight_stream_sched_pkg::*;
#(
  parameter int unsigned       HIDDEN_SIZE = 512,
  parameter int unsigned       INPUT_SIZE  = 96,
  parameter int unsigned       BURST_LEN   = 64,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk_200m,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_en,
  input  logic              stop,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_len,
  input  logic              rd_ack,
  input  logic              rd_data_valid,
  input  logic [15:0]       rd_data,
  output logic              rd_data_ready,
  input  logic              fifo_ready,
  output logic              wr_fifo_data_valid,
  output logic [15:0]       wr_fifo_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic              protocol_err,
  output logic [31:0]       stall_cycles
);

  localparam int unsigned TOTAL_WORDS = lstm_total_words(HIDDEN_SIZE, INPUT_SIZE);
  localparam int unsigned IDX_W       = $clog2(TOTAL_WORDS + 1);

  wsched_state_t    state, state_n;
  logic             stop_pend, stop_pend_n;
  logic [IDX_W-1:0] word_idx, word_idx_inc, addr_idx;
  logic             word_clr, word_inc, addr_load;
  logic             beat_clr, beat_inc, beat_term;

  assign word_idx_inc = word_idx + IDX_W'(1);

  wsched_burst_ctr #(.BURST_LEN(BURST_LEN)) u_burst_ctr (
    .clk_200m (clk_200m),
    .rst      (rst),
    .clr      (beat_clr),
    .inc      (beat_inc),
    .term     (beat_term)
  );

  // State register.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state, handshake outputs and datapath strobes.
  always_comb begin
    state_n       = state;
    stop_pend_n   = stop_pend;
    word_clr      = 1'b0;
    word_inc      = 1'b0;
    addr_load     = 1'b0;
    addr_idx      = '0;
    beat_clr      = 1'b0;
    beat_inc      = 1'b0;
    rd_req        = 1'b0;
    rd_data_ready = 1'b0;
    done          = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n   = S_REQ;
          word_clr  = 1'b1;
          addr_load = 1'b1;
        end
      end
      S_REQ: begin
        rd_req = fifo_ready;
        if (stop) stop_pend_n = 1'b1;
        if (rd_req && rd_ack) begin
          state_n  = S_XFER;
          beat_clr = 1'b1;
        end else if (stop) begin
          state_n = S_IDLE;
        end
      end
      S_XFER: begin
        rd_data_ready = 1'b1;
        if (stop) stop_pend_n = 1'b1;
        if (rd_data_valid) begin
          beat_inc = 1'b1;
          word_inc = 1'b1;
          if (beat_term) begin
            if (word_idx_inc == IDX_W'(TOTAL_WORDS)) begin
              state_n = S_DONE;
            end else if (stop_pend_n) begin
              state_n = S_IDLE;
            end else begin
              state_n   = S_REQ;
              addr_load = 1'b1;
              addr_idx  = word_idx_inc;
            end
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        word_clr = 1'b1;
        if (stop) stop_pend_n = 1'b1;
        if (loop_en && !stop_pend_n) begin
          state_n   = S_REQ;
          addr_load = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A pending stop is consumed once the frame parks in IDLE.
    if (state_n == S_IDLE) stop_pend_n = 1'b0;
  end

  // Pending stop flag, honoured at the next burst boundary.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) stop_pend <= 1'b0;
    else     stop_pend <= stop_pend_n;
  end

  // Word position within the frame; exact compare against TOTAL_WORDS, never wraps.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst)           word_idx <= '0;
    else if (word_clr) word_idx <= '0;
    else if (word_inc) word_idx <= word_idx_inc;
  end

  // Burst address and length latched on REQ entry, stable while the request is pending.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rd_len  <= '0;
    end else if (addr_load) begin
      rd_addr <= BASE_ADDR + (ADDR_W'(addr_idx) << 1);
      rd_len  <= 16'(BURST_LEN);
    end
  end

  // One-cycle registered forward of accepted beats to the gate FIFOs.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      wr_fifo_data_valid <= 1'b0;
      wr_fifo_data       <= '0;
    end else begin
      wr_fifo_data_valid <= beat_inc;
      if (beat_inc) wr_fifo_data <= rd_data;
    end
  end

  // Completed frame counter, wraps at 16 bits.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst)       frame_cnt <= '0;
    else if (done) frame_cnt <= frame_cnt + 16'd1;
  end

  // Sticky flag for beats that arrive when no burst is being accepted.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst)                                   protocol_err <= 1'b0;
    else if (rd_data_valid && state != S_XFER) protocol_err <= 1'b1;
  end

`ifdef WSCHED_STALL_CNT_EN
  // Saturating count of REQ cycles held off by FIFO back-pressure; cleared on frame start.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (state == S_IDLE && start && !stop)
      stall_cycles <= '0;
    else if (state == S_REQ && !fifo_ready && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_weight_stream_sched.sv
// Self-checking bench for weight_stream_sched with reduced frame dimensions.
module tb_weight_stream_sched;

  localparam int unsigned H     = 8;
  localparam int unsigned I     = 4;
  localparam int unsigned BL    = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned TOTAL = H * H * 5 / 2 + I * H * 2;

`ifdef WSCHED_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd50;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic          clk_200m = 1'b0;
  logic          rst = 1'b1;
  logic          start, loop_en, stop;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_len;
  logic          rd_ack, rd_data_valid;
  logic [15:0]   rd_data;
  logic          rd_data_ready, fifo_ready;
  logic          wr_fifo_data_valid;
  logic [15:0]   wr_fifo_data;
  logic          busy, done;
  logic [15:0]   frame_cnt;
  logic          protocol_err;
  logic [31:0]   stall_cycles;

  int checks = 0;
  int errors = 0;

  int ack_cnt = 0, strobe_cnt = 0, done_cnt = 0;
  logic [AW-1:0] last_ack_addr = '0;
  int inject_req = 0;
  int a0, s0, d0;

  always #5 clk_200m = ~clk_200m;

  weight_stream_sched #(
    .HIDDEN_SIZE (H),
    .INPUT_SIZE  (I),
    .BURST_LEN   (BL),
    .ADDR_W      (AW),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk_200m           (clk_200m),
    .rst                (rst),
    .start              (start),
    .loop_en            (loop_en),
    .stop               (stop),
    .rd_req             (rd_req),
    .rd_addr            (rd_addr),
    .rd_len             (rd_len),
    .rd_ack             (rd_ack),
    .rd_data_valid      (rd_data_valid),
    .rd_data            (rd_data),
    .rd_data_ready      (rd_data_ready),
    .fifo_ready         (fifo_ready),
    .wr_fifo_data_valid (wr_fifo_data_valid),
    .wr_fifo_data       (wr_fifo_data),
    .busy               (busy),
    .done               (done),
    .frame_cnt          (frame_cnt),
    .protocol_err       (protocol_err),
    .stall_cycles       (stall_cycles)
  );

  // Memory content: word i of the frame.
  function automatic logic [15:0] mem_word(input int unsigned i);
    return 16'(i * 73 + 4951);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic snap();
    a0 = ack_cnt; s0 = strobe_cnt; d0 = done_cnt;
  endtask

  task automatic pulse_start(input logic with_stop);
    @(posedge clk_200m); #1;
    start = 1'b1; stop = with_stop;
    @(posedge clk_200m); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(posedge clk_200m); #3;
    end
    chk("wait_done", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && ack_cnt < target; i++) begin
      @(posedge clk_200m); #3;
    end
    chk("wait_acks", 64'(ack_cnt >= target), 64'd1);
  endtask

  // Memory reader: acks a visible request, then streams BL beats read from the addressed words.
  initial begin : reader
    int beats_left;
    int unsigned cur_word;
    int inject_done;
    beats_left = 0; cur_word = 0; inject_done = 0;
    rd_ack = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk_200m); #2;
      rd_ack = 1'b0; rd_data_valid = 1'b0;
      if (rst) begin
        beats_left = 0;
      end else if (inject_done != inject_req) begin
        rd_data_valid = 1'b1; rd_data = 16'hBEEF; inject_done = inject_req;
      end else if (beats_left > 0) begin
        rd_data_valid = 1'b1; rd_data = mem_word(cur_word);
        cur_word++; beats_left--;
      end else if (rd_req) begin
        rd_ack = 1'b1; cur_word = rd_addr >> 1; beats_left = BL;
      end
    end
  end

  // Frame model: a frame is TOTAL words in order, requested BL at a time from address 0 upward;
  // done coincides with the strobe carrying the last word of the frame.
  initial begin : monitor
    int unsigned exp_wr, exp_req_word;
    logic exp_done;
    exp_wr = 0; exp_req_word = 0;
    forever begin
      @(negedge clk_200m);
      if (rst) begin
        exp_wr = 0; exp_req_word = 0;
      end else begin
        if (start && !stop && !busy) begin
          exp_wr = 0; exp_req_word = 0;
        end
        if (!fifo_ready) chk("rd_req_throttle", 64'(rd_req), 64'd0);
        if (rd_req && rd_ack) begin
          chk("rd_addr", 64'(rd_addr), 64'(exp_req_word * 2));
          chk("rd_len", 64'(rd_len), 64'(BL));
          exp_req_word += BL;
          ack_cnt++;
          last_ack_addr = rd_addr;
        end
        exp_done = wr_fifo_data_valid && (exp_wr == TOTAL - 1);
        chk("done", 64'(done), 64'(exp_done));
        if (wr_fifo_data_valid) begin
          chk("wr_data", 64'(wr_fifo_data), 64'(mem_word(exp_wr)));
          exp_wr++;
          strobe_cnt++;
        end
        if (done) done_cnt++;
        if (exp_done) begin
          exp_wr = 0; exp_req_word = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    int bad;
    logic found;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; fifo_ready = 1'b1;

    repeat (3) @(negedge clk_200m);
    chk("rst_rd_req",   64'(rd_req), 64'd0);
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_wr_valid", 64'(wr_fifo_data_valid), 64'd0);
    chk("rst_frame",    64'(frame_cnt), 64'd0);
    chk("rst_rd_addr",  64'(rd_addr), 64'd0);
    @(posedge clk_200m); #1 rst = 1'b0;

    // Single frame
    snap(); pulse_start(1'b0);
    wait_done(d0 + 1, 1000);
    repeat (3) @(posedge clk_200m); #3;
    chk("t1_acks",      64'(ack_cnt - a0), 64'd28);
    chk("t1_strobes",   64'(strobe_cnt - s0), 64'd224);
    chk("t1_dones",     64'(done_cnt - d0), 64'd1);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t1_idle",      64'(busy), 64'd0);
    chk("t1_last_addr", 64'(last_ack_addr), 64'd432);

    // Back-pressure stall before the 3rd burst
    snap(); pulse_start(1'b0);
    wait_acks(a0 + 2, 200);
    @(posedge clk_200m); #1 fifo_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_200m);
      if (busy && !rd_data_ready && !done) found = 1'b1;
    end
    chk("t2_reach_req", 64'(found), 64'd1);
    bad = 0;
    for (int i = 1; i < 50; i++) begin
      @(negedge clk_200m);
      if (rd_req || wr_fifo_data_valid) bad++;
    end
    chk("t2_stall_quiet", 64'(bad), 64'd0);
    @(posedge clk_200m); #1 fifo_ready = 1'b1;
    wait_done(d0 + 1, 1000);
    @(posedge clk_200m); #3;
    chk("t2_stall_cycles", 64'(stall_cycles), 64'(EXP_STALL));
    chk("t2_strobes",   64'(strobe_cnt - s0), 64'd224);
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);

    // Looping for three frames
    snap(); loop_en = 1'b1; pulse_start(1'b0);
    chk("t3_stall_clr", 64'(stall_cycles), 64'd0);
    wait_done(d0 + 2, 1200);
    loop_en = 1'b0;
    wait_done(d0 + 3, 700);
    repeat (3) @(posedge clk_200m); #3;
    chk("t3_strobes",   64'(strobe_cnt - s0), 64'd672);
    chk("t3_acks",      64'(ack_cnt - a0), 64'd84);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd5);
    chk("t3_idle",      64'(busy), 64'd0);

    // Stop during burst 5, then a fresh frame
    snap(); pulse_start(1'b0);
    wait_acks(a0 + 5, 300);
    stop = 1'b1;
    @(posedge clk_200m); #1 stop = 1'b0;
    repeat (20) @(posedge clk_200m); #3;
    chk("t4_idle",    64'(busy), 64'd0);
    chk("t4_strobes", 64'(strobe_cnt - s0), 64'd40);
    chk("t4_acks",    64'(ack_cnt - a0), 64'd5);
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    snap(); pulse_start(1'b0);
    wait_acks(a0 + 1, 20);
    chk("t4_restart_addr", 64'(last_ack_addr), 64'd0);
    wait_done(d0 + 1, 1000);
    @(posedge clk_200m); #3;
    chk("t4_strobes2",  64'(strobe_cnt - s0), 64'd224);
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd6);

    // Stray beat in IDLE
    repeat (2) @(posedge clk_200m); #3;
    chk("t5_perr_pre", 64'(protocol_err), 64'd0);
    inject_req++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_200m);
      if (wr_fifo_data_valid) bad++;
    end
    chk("t5_no_strobe", 64'(bad), 64'd0);
    @(posedge clk_200m); #3;
    chk("t5_perr_set", 64'(protocol_err), 64'd1);
    repeat (5) @(posedge clk_200m); #3;
    chk("t5_perr_held", 64'(protocol_err), 64'd1);
    chk("t5_idle",      64'(busy), 64'd0);

    // Asynchronous reset in the middle of a burst
    snap(); pulse_start(1'b0);
    wait_acks(a0 + 2, 100);
    @(posedge clk_200m); #3;
    rst = 1'b1; #1;
    chk("t5_rst_rd_req",  64'(rd_req), 64'd0);
    chk("t5_rst_busy",    64'(busy), 64'd0);
    chk("t5_rst_ready",   64'(rd_data_ready), 64'd0);
    chk("t5_rst_wvalid",  64'(wr_fifo_data_valid), 64'd0);
    chk("t5_rst_wdata",   64'(wr_fifo_data), 64'd0);
    chk("t5_rst_frame",   64'(frame_cnt), 64'd0);
    chk("t5_rst_perr",    64'(protocol_err), 64'd0);
    chk("t5_rst_addr",    64'(rd_addr), 64'd0);
    chk("t5_rst_len",     64'(rd_len), 64'd0);
    chk("t5_rst_stall",   64'(stall_cycles), 64'd0);
    repeat (2) @(posedge clk_200m); #1 rst = 1'b0;

    // start+stop together in IDLE, then start while busy
    pulse_start(1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_200m);
      if (rd_req || busy) bad++;
    end
    chk("t6_start_stop_ignored", 64'(bad), 64'd0);
    snap(); pulse_start(1'b0);
    wait_acks(a0 + 3, 100);
    pulse_start(1'b0);
    wait_done(d0 + 1, 1000);
    repeat (20) @(posedge clk_200m); #3;
    chk("t6_strobes",   64'(strobe_cnt - s0), 64'd224);
    chk("t6_acks",      64'(ack_cnt - a0), 64'd28);
    chk("t6_dones",     64'(done_cnt - d0), 64'd1);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t6_idle",      64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
